// File: rtl/alu_operand_sequencer_if.sv
// Bus between the operand sequencer, its input source (switches/buttons) and the 6-bit mini ALU.
// The sequencer uses the slave modport; the source/ALU side uses master.
interface alu_operand_sequencer_if #(
  parameter int unsigned WIDTH = 6,
  parameter int unsigned FXN_W = 3,
  parameter int unsigned CNT_W = 8
);
  logic [WIDTH-1:0] din;
  logic             load;
  logic             go;
  logic [WIDTH-1:0] a_out;
  logic [WIDTH-1:0] b_out;
  logic [FXN_W-1:0] fxn_out;
  logic [WIDTH-1:0] x_in;
  logic [WIDTH-1:0] result;
  logic             result_valid;
  logic             busy;
  logic [1:0]       need;
  logic [CNT_W-1:0] op_count;

  modport master (
    output din, load, go, x_in,
    input  a_out, b_out, fxn_out, result, result_valid, busy, need, op_count
  );

  modport slave (
    input  din, load, go, x_in,
    output a_out, b_out, fxn_out, result, result_valid, busy, need, op_count
  );
endinterface

// File: rtl/alu_operand_sequencer.sv
// Serially collects A, B and fxn from a shared bus, drives them into the mini ALU and
// captures its output on a go strobe. All outputs are registered.
module alu_operand_sequencer #(
  parameter int unsigned WIDTH = 6,
  parameter int unsigned FXN_W = 3,
  parameter int unsigned CNT_W = 8
) (
  input logic                   clk,
  input logic                   reset,
  alu_operand_sequencer_if.slave bus
);

  typedef enum logic [2:0] {StWaitA, StWaitB, StWaitF, StReady, StExec, StDone} state_e;

  localparam logic [1:0] NeedA    = 2'b00;
  localparam logic [1:0] NeedB    = 2'b01;
  localparam logic [1:0] NeedFxn  = 2'b10;
  localparam logic [1:0] NeedNone = 2'b11;

  state_e state;

  // busy and need are registered alongside state so they decode from state only.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state            <= StWaitA;
      bus.a_out        <= '0;
      bus.b_out        <= '0;
      bus.fxn_out      <= '0;
      bus.result       <= '0;
      bus.result_valid <= 1'b0;
      bus.busy         <= 1'b0;
      bus.need         <= NeedA;
      bus.op_count     <= '0;
    end else begin
      unique case (state)
        StWaitA: begin
          if (bus.load) begin
            bus.a_out <= bus.din;
            bus.need  <= NeedB;
            state     <= StWaitB;
          end
        end
        StWaitB: begin
          if (bus.load) begin
            bus.b_out <= bus.din;
            bus.need  <= NeedFxn;
            state     <= StWaitF;
          end
        end
        StWaitF: begin
          if (bus.load) begin
            bus.fxn_out <= bus.din[FXN_W-1:0];
            bus.need    <= NeedNone;
            state       <= StReady;
          end
        end
        StReady: begin
          if (bus.go) begin
            bus.busy <= 1'b1;
            state    <= StExec;
          end
        end
        StExec: begin
          bus.result       <= bus.x_in[WIDTH-1:0];
          bus.result_valid <= 1'b1;
          bus.op_count     <= bus.op_count + CNT_W'(1);
          bus.busy         <= 1'b0;
          state            <= StDone;
        end
        StDone: begin
          // go has priority; a simultaneous load is dropped.
          if (bus.go) begin
            bus.busy <= 1'b1;
            state    <= StExec;
          end else if (bus.load) begin
            bus.a_out        <= bus.din;
            bus.result_valid <= 1'b0;
            bus.need         <= NeedB;
            state            <= StWaitB;
          end
        end
        default: begin
          bus.busy <= 1'b0;
          bus.need <= NeedA;
          state    <= StWaitA;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Directed and randomized checks of alu_operand_sequencer against an item-counting reference model.
module tb_alu_operand_sequencer;
  localparam int unsigned W = 6;
  localparam int unsigned F = 3;
  localparam int unsigned C = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  alu_operand_sequencer_if #(.WIDTH(W), .FXN_W(F), .CNT_W(C)) bus ();

  alu_operand_sequencer #(.WIDTH(W), .FXN_W(F), .CNT_W(C)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model: number of items collected, whether an execution is in flight,
  // and whether the current operand set has been executed at least once.
  logic [W-1:0] m_a, m_b, m_res;
  logic [F-1:0] m_f;
  logic         m_valid;
  logic [C-1:0] m_cnt;
  int           m_items;
  bit           m_exec, m_done;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_a = '0; m_b = '0; m_f = '0; m_res = '0; m_valid = 1'b0; m_cnt = '0;
    m_items = 0; m_exec = 1'b0; m_done = 1'b0;
  endtask

  task automatic model_edge(input bit ld, input bit g, input logic [W-1:0] d,
                            input logic [W-1:0] x);
    if (m_exec) begin
      m_res = x; m_valid = 1'b1; m_cnt = m_cnt + 1'b1; m_exec = 1'b0; m_done = 1'b1;
    end else if (m_items == 3) begin
      if (g) m_exec = 1'b1;
      else if (ld && m_done) begin
        m_a = d; m_items = 1; m_done = 1'b0; m_valid = 1'b0;
      end
    end else if (ld) begin
      if (m_items == 0) m_a = d;
      else if (m_items == 1) m_b = d;
      else m_f = d[F-1:0];
      m_items++;
    end
  endtask

  task automatic check_all(input string t);
    logic [1:0] exp_need;
    exp_need = (m_items < 3) ? 2'(m_items) : 2'b11;
    check({t, ".a"}, 32'(bus.a_out), 32'(m_a));
    check({t, ".b"}, 32'(bus.b_out), 32'(m_b));
    check({t, ".fxn"}, 32'(bus.fxn_out), 32'(m_f));
    check({t, ".result"}, 32'(bus.result), 32'(m_res));
    check({t, ".valid"}, 32'(bus.result_valid), 32'(m_valid));
    check({t, ".busy"}, 32'(bus.busy), 32'(m_exec));
    check({t, ".need"}, 32'(bus.need), 32'(exp_need));
    check({t, ".count"}, 32'(bus.op_count), 32'(m_cnt));
  endtask

  task automatic step(input string t, input bit ld, input bit g, input logic [W-1:0] d,
                      input logic [W-1:0] x);
    bus.load = ld; bus.go = g; bus.din = d; bus.x_in = x;
    @(posedge clk);
    model_edge(ld, g, d, x);
    #1;
    check_all(t);
  endtask

  task automatic do_reset();
    bus.load = 1'b0; bus.go = 1'b0; bus.din = '0; bus.x_in = '0;
    #2 reset = 1'b1;
    model_reset();
    #1 check_all("reset");
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    bus.load = 1'b0; bus.go = 1'b0; bus.din = '0; bus.x_in = '0;
    model_reset();
    @(posedge clk); #1;
    check_all("por");
    @(negedge clk);
    reset = 1'b0;

    // Basic load/execute.
    step("ldA", 1, 0, 6'd4, 6'd0);
    step("ldB", 1, 0, 6'd3, 6'd0);
    step("ldF", 1, 0, 6'b000000, 6'd0);
    check("tp1.need", 32'(bus.need), 32'd3);
    step("go1", 0, 1, 6'd0, 6'd7);
    check("tp1.busy", 32'(bus.busy), 32'd1);
    step("exec1", 0, 0, 6'd0, 6'd7);
    check("tp1.result", 32'(bus.result), 32'd7);
    check("tp1.count", 32'(bus.op_count), 32'd1);
    check("tp1.busy_off", 32'(bus.busy), 32'd0);

    // Negative operands, fxn upper bits dropped.
    step("ldA2", 1, 0, 6'b111011, 6'd0);
    step("ldB2", 1, 0, 6'b111011, 6'd0);
    step("ldF2", 1, 0, 6'b101001, 6'd0);
    check("tp2.fxn", 32'(bus.fxn_out), 32'd1);
    step("go2", 0, 1, 6'd0, 6'b110110);
    step("exec2", 0, 0, 6'd0, 6'b110110);
    check("tp2.result", 32'(bus.result), 32'b110110);

    // Re-execute from DONE, valid stays high, then load leaves DONE.
    step("go3", 0, 1, 6'd0, 6'd20);
    check("tp3.valid_exec", 32'(bus.result_valid), 32'd1);
    step("exec3", 0, 0, 6'd0, 6'd20);
    check("tp3.result", 32'(bus.result), 32'd20);
    check("tp3.count", 32'(bus.op_count), 32'd3);
    step("ld27", 1, 0, 6'd27, 6'd0);
    check("tp3.a", 32'(bus.a_out), 32'd27);
    check("tp3.valid", 32'(bus.result_valid), 32'd0);
    check("tp3.need", 32'(bus.need), 32'd1);

    // go ignored in WAIT_B; load+go in READY executes without touching operands.
    step("goWB", 0, 1, 6'd9, 6'd0);
    check("tp4.busy", 32'(bus.busy), 32'd0);
    step("ldB4", 1, 0, 6'd5, 6'd0);
    step("ldF4", 1, 0, 6'd2, 6'd0);
    step("ldgo", 1, 1, 6'd60, 6'd11);
    check("tp4.busy_exec", 32'(bus.busy), 32'd1);
    check("tp4.a", 32'(bus.a_out), 32'd27);
    check("tp4.b", 32'(bus.b_out), 32'd5);
    step("exec4", 1, 0, 6'd61, 6'd11);

    // Async reset in the middle of EXEC.
    step("go5", 0, 1, 6'd0, 6'd33);
    do_reset();
    check("tp5.count", 32'(bus.op_count), 32'd0);
    step("post_rst", 0, 0, 6'd0, 6'd33);

    // Counter wrap after 256 executions.
    step("wA", 1, 0, 6'd1, 6'd0);
    step("wB", 1, 0, 6'd2, 6'd0);
    step("wF", 1, 0, 6'd3, 6'd0);
    for (int i = 0; i < 256; i++) begin
      step("wgo", 0, 1, 6'd0, 6'd42);
      step("wex", 0, 0, 6'd0, 6'd42);
    end
    check("wrap.count", 32'(bus.op_count), 32'd0);
    check("wrap.valid", 32'(bus.result_valid), 32'd1);
    check("wrap.result", 32'(bus.result), 32'd42);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) do_reset();
      else step("rand", ($urandom_range(0, 9) < 4), ($urandom_range(0, 9) < 3),
                W'($urandom), W'($urandom));
    end

    bus.load = 1'b0; bus.go = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/alu_operand_sequencer.md
Name: alu_operand_sequencer

Overview:
- Upstream/downstream wrapper stage for the 6-bit mini ALU (ports A, B, fxn[2:0], X).
- Collects A, B and fxn serially from one shared 6-bit input bus, one load strobe per item.
- Drives the registered operands into the ALU and, on a go strobe, captures X into a held result register with a valid flag.
- Intended for board use: a switch bank plus two debounced, single-cycle button pulses.

Parameters:
- WIDTH, 6, data width of A, B, X and din.
- FXN_W, 3, width of the function select; it is taken from din[FXN_W-1:0].
- CNT_W, 8, width of the completed-operation counter.

Ports:
- clk  in  1  system clock, rising-edge active.
- reset  in  1  asynchronous, active-high reset.
- din  in  WIDTH  shared operand/function input bus.
- load  in  1  single-cycle strobe; captures din into the currently awaited item.
- go  in  1  single-cycle strobe; starts execution.
- a_out  out  WIDTH  registered A to ALU.A.
- b_out  out  WIDTH  registered B to ALU.B.
- fxn_out  out  FXN_W  registered function to ALU.fxn.
- x_in  in  WIDTH  ALU.X, combinational from a_out/b_out/fxn_out.
- result  out  WIDTH  captured ALU output.
- result_valid  out  1  result holds the output of the most recent execution.
- busy  out  1  high during EXEC.
- need  out  2  item awaited: 00=A, 01=B, 10=fxn, 11=none (READY/EXEC/DONE).
- op_count  out  CNT_W  number of completed executions.

Behaviour:
- Reset (asynchronous, active-high, any time):
  - state=WAIT_A.
  - a_out, b_out, fxn_out, result, op_count = 0.
  - result_valid=0, busy=0, need=00.
  - Reset mid-EXEC aborts the execution: no capture, no count.
- States and transitions (all transitions on rising clk):
  - WAIT_A: load -> a_out<=din, go to WAIT_B.
  - WAIT_B: load -> b_out<=din, go to WAIT_F.
  - WAIT_F: load -> fxn_out<=din[FXN_W-1:0] (upper din bits ignored), go to READY.
  - READY: go -> EXEC. load is ignored.
  - EXEC: lasts exactly one cycle, busy=1, operands stable. At the end of the cycle: result<=x_in, result_valid<=1, op_count<=op_count+1, go to DONE.
  - DONE: operands and result held.
    - go -> EXEC: re-executes with the same operands, and result_valid stays 1 through EXEC.
    - load -> a_out<=din, result_valid<=0, go to WAIT_B.
- Strobe rules:
  - go is ignored in WAIT_A/B/F and in EXEC.
  - load is ignored in EXEC.
  - load and go together: in READY, go wins. In DONE, go wins and load is dropped. In WAIT_* states, load acts and go is ignored.
  - A strobe held high for several cycles counts as one event per cycle; the source must pulse.
- Latency: go sampled at edge N gives busy=1 in cycle N..N+1, then result/result_valid updated at edge N+1 and visible after it.
- Width/arithmetic:
  - No arithmetic in this block; x_in is captured verbatim, with two's-complement sign preserved.
  - op_count wraps modulo 2^CNT_W (255 -> 0); wrap has no effect on result_valid.
- Outputs are all registered; need and busy decode from state only.
- Operands change only on an accepted load, so the ALU input is glitch-free between loads.

Test Plan:
- Reset, then load din=4, 3, 6'b000000 on three separate cycles -> a_out=4, b_out=3, fxn_out=000, need=11. Then go with bench driving x_in=6'd7 -> busy=1 for one cycle, result=7, result_valid=1, op_count=1.
- Load A=6'b111011 (-5), B=6'b111011, din=6'b101001 for fxn -> fxn_out=001 (upper bits dropped). Then go with x_in=6'b110110 -> result=6'b110110.
- In DONE, pulse go again with x_in=6'd20 -> result=20, op_count increments, result_valid never drops. Then load din=27 -> a_out=27, result_valid=0, need=01.
- In WAIT_B, pulse go -> no state change, busy stays 0. In READY, assert load and go in the same cycle -> EXEC entered, a_out/b_out unchanged.
- Assert reset asynchronously mid-EXEC (between edges) -> all outputs 0 immediately, need=00, op_count not incremented.
- Execute 256 times with a fixed x_in -> op_count returns to 0, result_valid=1, result unchanged.
